// File: rtl/sd_credit_tx_if.sv
// Consumer (srdy/drdy) and credit link signals of sd_credit_tx.
// master = the transmitter block, slave = its environment (upstream source + remote receiver).
interface sd_credit_tx_if #(
    parameter int width = 8
);
    logic             c_srdy;
    logic             c_drdy;
    logic [width-1:0] c_data;
    logic             p_vld;
    logic [width-1:0] p_data;
    logic             p_credit;

    modport master (
        input  c_srdy, c_data, p_credit,
        output c_drdy, p_vld, p_data
    );

    modport slave (
        output c_srdy, c_data, p_credit,
        input  c_drdy, p_vld, p_data
    );
endinterface

// File: rtl/sd_credit_tx.sv
// Credit-based link transmitter: accepts a word only while a credit is held,
// forwards it one cycle later on the link, and counts credits returned by the receiver.
module sd_credit_tx #(
    parameter  int width   = 8,
    parameter  int credits = 4,
    localparam int cw      = $clog2(credits + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    sd_credit_tx_if.master  link,
    output logic [cw-1:0]   credit_cnt_o,
    output logic            err_overflow_o
);

    localparam logic [cw-1:0] CNT_MAX = cw'(credits);

    logic             credit_q, credit_d;
    logic [cw-1:0]    cnt_q, cnt_d;
    logic             p_vld_q, p_vld_d;
    logic [width-1:0] p_data_q, p_data_d;
    logic             err_q, err_d;
    logic             can_accept;
    logic             xfer;

    // drdy depends only on the counter flop, never on c_srdy or p_credit
    assign can_accept = (cnt_q != '0);
    assign xfer       = link.c_srdy & can_accept;

    always_comb begin
        credit_d = link.p_credit;
        cnt_d    = cnt_q;
        err_d    = err_q;
        p_vld_d  = xfer;
        p_data_d = p_data_q;
        if (xfer) begin
            p_data_d = link.c_data;
        end
        unique case ({xfer, credit_q})
            2'b10: cnt_d = cnt_q - cw'(1);
            2'b01: begin
                // a credit returned on top of a full counter is a protocol error
                if (cnt_q == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= 1'b0;
            cnt_q    <= CNT_MAX;
            p_vld_q  <= 1'b0;
            p_data_q <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            p_vld_q  <= p_vld_d;
            p_data_q <= p_data_d;
            err_q    <= err_d;
        end
    end

    assign link.c_drdy    = can_accept;
    assign link.p_vld     = p_vld_q;
    assign link.p_data    = p_data_q;
    assign credit_cnt_o   = cnt_q;
    assign err_overflow_o = err_q;

endmodule

// File: tb/tb_sd_credit_tx.sv
// Bench for sd_credit_tx: directed vector table, hand sequences for loopback
// and async reset, and randomized traffic against a credit-arithmetic model.
module tb_sd_credit_tx;

    localparam int W  = 8;
    localparam int CR = 4;
    localparam int CW = $clog2(CR + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cnt;
    logic          err;

    sd_credit_tx_if #(.width(W)) link ();

    sd_credit_tx #(.width(W), .credits(CR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .link           (link),
        .credit_cnt_o   (cnt),
        .err_overflow_o (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: credits held = start - words accepted + credits landed, clamped at max
    int     m_cnt;
    bit     m_credq;
    bit     m_pvld;
    bit     m_err;
    logic [W-1:0] m_pdata;
    int     cyc = 0;

    typedef struct {
        bit           srdy;
        logic [W-1:0] data;
        bit           credit;
        bit           e_drdy;
        bit           e_pvld;
        logic [W-1:0] e_pdata;
        int           e_cnt;
        bit           e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit s, logic [W-1:0] d, bit c, bit dr, bit pv,
                                logic [W-1:0] pd, int n, bit e);
        vec_t v;
        v.srdy = s; v.data = d; v.credit = c;
        v.e_drdy = dr; v.e_pvld = pv; v.e_pdata = pd; v.e_cnt = n; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = CR; m_credq = 1'b0; m_pvld = 1'b0; m_err = 1'b0; m_pdata = '0;
    endtask

    task automatic step(input bit s, input logic [W-1:0] d, input bit c);
        bit x;
        link.c_srdy   = s;
        link.c_data   = d;
        link.p_credit = c;
        x = s && (m_cnt != 0);
        @(posedge clk);
        #1;
        cyc++;
        m_pvld = x;
        if (x) m_pdata = d;
        m_cnt = m_cnt - int'(x) + int'(m_credq);
        if (m_cnt > CR) begin
            m_cnt = CR;
            m_err = 1'b1;
        end
        m_credq = c;
        if (x) $display("cycle %0d: accept data=0x%02h credit_cnt=%0d", cyc, d, cnt);
        chk("credit_cnt", int'(cnt), m_cnt);
        chk("c_drdy", int'(link.c_drdy), int'(m_cnt != 0));
        chk("p_vld", int'(link.p_vld), int'(m_pvld));
        chk("p_data", int'(link.p_data), int'(m_pdata));
        chk("err_overflow", int'(err), int'(m_err));
    endtask

    initial begin
        int     words;
        bit     obs[$];
        int     pend;
        bit     c;
        logic [W-1:0] seq;

        link.c_srdy = 1'b0; link.c_data = '0; link.p_credit = 1'b0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", int'(cnt), 4);
        chk("rst_drdy", int'(link.c_drdy), 1);
        chk("rst_pvld", int'(link.p_vld), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // burst, credit return, overflow and xfer+credit at max
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 4, 0));
        tbl.push_back(mk(1, 8'h01, 0, 1, 1, 8'h01, 3, 0));
        tbl.push_back(mk(1, 8'h02, 0, 1, 1, 8'h02, 2, 0));
        tbl.push_back(mk(1, 8'h03, 0, 1, 1, 8'h03, 1, 0));
        tbl.push_back(mk(1, 8'h04, 0, 0, 1, 8'h04, 0, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 0, 8'h04, 0, 0));
        tbl.push_back(mk(1, 8'h05, 1, 0, 0, 8'h04, 0, 0));
        tbl.push_back(mk(1, 8'h05, 0, 1, 0, 8'h04, 1, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 1, 8'h05, 0, 0));
        tbl.push_back(mk(0, 8'h06, 0, 0, 0, 8'h05, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h05, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h05, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h05, 2, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h05, 3, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h05, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h05, 4, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'h05, 4, 0));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 1, 8'hAA, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'hAA, 4, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 8'hAA, 4, 0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'hAA, 4, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'hAA, 4, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].srdy, tbl[i].data, tbl[i].credit);
            chk($sformatf("vec%0d_cnt", i), int'(cnt), tbl[i].e_cnt);
            chk($sformatf("vec%0d_drdy", i), int'(link.c_drdy), int'(tbl[i].e_drdy));
            chk($sformatf("vec%0d_pvld", i), int'(link.p_vld), int'(tbl[i].e_pvld));
            chk($sformatf("vec%0d_pdata", i), int'(link.p_data), int'(tbl[i].e_pdata));
            chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].e_err));
        end

        // async reset mid-burst with one credit left and a word on the link
        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        chk("pre_rst_cnt", int'(cnt), 1);
        chk("pre_rst_pvld", int'(link.p_vld), 1);
        link.c_srdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pvld", int'(link.p_vld), 0);
        chk("async_rst_cnt", int'(cnt), 4);
        chk("async_rst_err", int'(err), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // loopback: receiver returns each credit one register after p_vld
        obs.push_back(1'b0);
        obs.push_back(1'b0);
        words = 0;
        seq   = 8'h40;
        for (int i = 0; i < 100; i++) begin
            step(1, seq, obs[obs.size() - 2]);
            seq++;
            obs.push_back(link.p_vld);
            if (link.p_vld) words++;
            chk("loop_cnt_range", int'(cnt >= 1 && cnt <= 4), 1);
        end
        chk("loop_throughput", words, 100);
        for (int i = 0; i < 6; i++) begin
            step(0, 8'h00, obs[obs.size() - 2]);
            obs.push_back(link.p_vld);
        end
        chk("loop_drain_cnt", int'(cnt), 4);

        // random traffic with delayed credit returns and occasional spurious credits
        pend = 0;
        for (int i = 0; i < 300; i++) begin
            c = (pend > 0) && ($urandom_range(0, 1) == 1);
            if (c) pend--;
            if ($urandom_range(0, 39) == 0) c = 1'b1;
            step(bit'($urandom_range(0, 1)), W'($urandom), c);
            if (link.p_vld) pend++;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
